// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD time-of-day counter with button-driven set mode and blink flags
// Ports: CLK system clock; RST async active-high reset; EN1HZ 1-cycle second tick;
//   SIG2HZ blink square wave; BTN_MODE/BTN_UP debounced async buttons;
//   HOUR/MIN/SEC registered BCD time; BLANK_H/BLANK_M blink flags for the field being set;
//   SETTING high outside RUN.
module time_keeper (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SIG2HZ,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic       BLANK_H,
  output logic       BLANK_M,
  output logic       SETTING
);
  typedef enum logic [1:0] {RUN, SET_H, SET_M} state_t;
  state_t state, state_next;
  logic [2:0] mode_sync, up_sync;
  logic mode_p, up_p, tick;
  logic [7:0] hour_next, min_next, sec_next;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    return v == last ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  // bits [1:0] synchronise, bit [2] holds the previous synchronised level for edge detection
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mode_sync <= '0;
      up_sync   <= '0;
    end else begin
      mode_sync <= {mode_sync[1:0], BTN_MODE};
      up_sync   <= {up_sync[1:0], BTN_UP};
    end

  assign mode_p = mode_sync[1] & ~mode_sync[2];
  // a mode press in the same cycle swallows the up press
  assign up_p   = up_sync[1] & ~up_sync[2] & ~mode_p;
  assign tick   = state == RUN & EN1HZ;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= RUN;
    else     state <= state_next;

  always_comb
    state_next = state == RUN   ? (mode_p ? SET_H : RUN) :
                 state == SET_H ? (mode_p ? SET_M : SET_H) :
                 state == SET_M ? (mode_p ? RUN : SET_M) : RUN;

  // leaving SET_M clears seconds; a tick is impossible then since the state is not RUN
  always_comb begin
    sec_next  = tick ? bcd_inc(SEC, 8'h59) : (state == SET_M && mode_p) ? 8'h00 : SEC;
    min_next  = (tick && SEC == 8'h59) || (state == SET_M && up_p) ? bcd_inc(MIN, 8'h59) : MIN;
    hour_next = (tick && SEC == 8'h59 && MIN == 8'h59) || (state == SET_H && up_p)
                ? bcd_inc(HOUR, 8'h23) : HOUR;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      HOUR <= 8'h00;
      MIN  <= 8'h00;
      SEC  <= 8'h00;
    end else begin
      HOUR <= hour_next;
      MIN  <= min_next;
      SEC  <= sec_next;
    end

  always_comb begin
    BLANK_H = state == SET_H && SIG2HZ;
    BLANK_M = state == SET_M && SIG2HZ;
    SETTING = state != RUN;
  end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized self-checking bench for time_keeper against a seconds-of-day model
module tb_time_keeper;
  logic CLK = 0, RST = 1, EN1HZ = 0, SIG2HZ = 0, BTN_MODE = 0, BTN_UP = 0;
  logic [7:0] HOUR, MIN, SEC;
  logic BLANK_H, BLANK_M, SETTING;
  int checks = 0, errors = 0;
  int mh = 0, mm = 0, ms = 0, mst = 0;

  time_keeper dut (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ),
    .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .BLANK_H(BLANK_H), .BLANK_M(BLANK_M), .SETTING(SETTING)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    repeat (6) @(posedge CLK);
    SIG2HZ = ~SIG2HZ;
  end

  function automatic logic [7:0] bcd(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(mh), bcd(mm), bcd(ms)};
  endfunction

  function automatic logic [2:0] exp_flags();
    return {mst == 1 && SIG2HZ, mst == 2 && SIG2HZ, mst != 0};
  endfunction

  task automatic model_tick();
    int t;
    t = ((mh * 60 + mm) * 60 + ms + 1) % 86400;
    mh = t / 3600;
    mm = (t / 60) % 60;
    ms = t % 60;
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mst = 0;
  endtask

  task automatic pulse_en();
    EN1HZ = 1;
    @(negedge CLK);
    EN1HZ = 0;
    if (mst == 0) model_tick();
  endtask

  // en asserts EN1HZ on exactly the edge where the button action lands
  task automatic press(input logic m, input logic u, input logic en);
    BTN_MODE = m;
    BTN_UP = u;
    @(negedge CLK);
    @(negedge CLK);
    EN1HZ = en;
    @(negedge CLK);
    EN1HZ = 0;
    if (en && mst == 0) model_tick();
    if (m) begin
      if (mst == 2) ms = 0;
      mst = (mst + 1) % 3;
    end else if (u) begin
      if (mst == 1) mh = (mh + 1) % 24;
      else if (mst == 2) mm = (mm + 1) % 60;
    end
    repeat (2) @(negedge CLK);
    BTN_MODE = 0;
    BTN_UP = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic goto_mode(input int target);
    while (mst != target) press(1, 0, 0);
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (2) @(negedge CLK);
    model_reset();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000000) begin
      errors++; $display("FAIL reset_time: got %h want 000000", {HOUR, MIN, SEC});
    end
    checks++;
    if ({BLANK_H, BLANK_M, SETTING} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {BLANK_H, BLANK_M, SETTING});
    end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_count();
    repeat (61) pulse_en();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000101) begin
      errors++; $display("FAIL count_61: got %h want 000101", {HOUR, MIN, SEC});
    end
    checks++;
    if ({HOUR, MIN, SEC} !== exp_time()) begin
      errors++; $display("FAIL count_model: got %h want %h", {HOUR, MIN, SEC}, exp_time());
    end
  endtask

  task automatic test_rollover();
    goto_mode(1);
    while (mh != 23) press(0, 1, 0);
    press(1, 0, 0);
    while (mm != 59) press(0, 1, 0);
    press(1, 0, 0);
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h235900) begin
      errors++; $display("FAIL preload_2359: got %h want 235900", {HOUR, MIN, SEC});
    end
    repeat (59) pulse_en();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h235959) begin
      errors++; $display("FAIL pre_roll: got %h want 235959", {HOUR, MIN, SEC});
    end
    pulse_en();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h000000 || exp_time() !== 24'h000000) begin
      errors++; $display("FAIL full_roll: got %h want %h", {HOUR, MIN, SEC}, exp_time());
    end
  endtask

  task automatic test_set_hour();
    int sec0;
    goto_mode(1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({BLANK_H, BLANK_M, SETTING} !== exp_flags()) begin
        errors++; $display("FAIL blank_h_follow: got %b want %b", {BLANK_H, BLANK_M, SETTING}, exp_flags());
      end
      @(negedge CLK);
    end
    while (mh != 5) press(0, 1, 0);
    sec0 = ms;
    repeat (24) begin
      press(0, 1, 0);
      pulse_en();
    end
    checks++;
    if (HOUR !== 8'h05) begin
      errors++; $display("FAIL hour_wrap24: got %h want 05", HOUR);
    end
    checks++;
    if (SEC !== bcd(sec0) || {HOUR, MIN, SEC} !== exp_time()) begin
      errors++; $display("FAIL hour_frozen: got %h want %h", {HOUR, MIN, SEC}, exp_time());
    end
  endtask

  task automatic test_set_min();
    goto_mode(1);
    while (mh != 10) press(0, 1, 0);
    press(1, 0, 0);
    while (mm != 20) press(0, 1, 0);
    press(1, 0, 0);
    repeat (37) pulse_en();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h102037) begin
      errors++; $display("FAIL reach_102037: got %h want 102037", {HOUR, MIN, SEC});
    end
    press(1, 0, 0);
    press(1, 0, 0);
    repeat (45) press(0, 1, 0);
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h100537 || exp_time() !== 24'h100537) begin
      errors++; $display("FAIL min_no_carry: got %h want %h", {HOUR, MIN, SEC}, exp_time());
    end
    press(1, 0, 0);
    checks++;
    if ({HOUR, MIN, SEC, SETTING} !== {24'h100500, 1'b0}) begin
      errors++; $display("FAIL exit_clear_sec: got %h/%b want 100500/0", {HOUR, MIN, SEC}, SETTING);
    end
    pulse_en();
    checks++;
    if ({HOUR, MIN, SEC} !== 24'h100501) begin
      errors++; $display("FAIL resume_count: got %h want 100501", {HOUR, MIN, SEC});
    end
  endtask

  task automatic test_simultaneous();
    int h0;
    goto_mode(1);
    h0 = mh;
    press(1, 1, 0);
    checks++;
    if (mst !== 2 || {BLANK_H, BLANK_M, SETTING} !== exp_flags() || HOUR !== bcd(h0)) begin
      errors++; $display("FAIL mode_beats_up: got %h/%b want %h/%b", HOUR, {BLANK_H, BLANK_M, SETTING}, bcd(h0), exp_flags());
    end
    press(1, 0, 1);
    checks++;
    if (SEC !== 8'h00 || SETTING !== 1'b0 || {HOUR, MIN, SEC} !== exp_time()) begin
      errors++; $display("FAIL en_on_exit: got %h/%b want %h/0", {HOUR, MIN, SEC}, SETTING, exp_time());
    end
    press(1, 0, 1);
    checks++;
    if (SEC !== 8'h01 || {HOUR, MIN, SEC} !== exp_time() || SETTING !== 1'b1) begin
      errors++; $display("FAIL en_on_enter: got %h/%b want %h/1", {HOUR, MIN, SEC}, SETTING, exp_time());
    end
  endtask

  task automatic test_async_reset();
    goto_mode(2);
    while (mm != 33) press(0, 1, 0);
    checks++;
    if (MIN !== 8'h33 || SETTING !== 1'b1) begin
      errors++; $display("FAIL pre_reset_set_m: got %h/%b want 33/1", MIN, SETTING);
    end
    @(negedge CLK);
    #2 RST = 1;
    model_reset();
    #1;
    checks++;
    if ({HOUR, MIN, SEC, BLANK_H, BLANK_M, SETTING} !== 27'h0) begin
      errors++; $display("FAIL async_reset: got %h/%b want 000000/000", {HOUR, MIN, SEC}, {BLANK_H, BLANK_M, SETTING});
    end
    BTN_MODE = 1;
    #1 RST = 0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (SETTING !== 1'b0) begin
      errors++; $display("FAIL held_btn_early: got %b want 0", SETTING);
    end
    @(negedge CLK);
    mst = 1;
    checks++;
    if (SETTING !== 1'b1) begin
      errors++; $display("FAIL held_btn_3edges: got %b want 1", SETTING);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if ({BLANK_H, BLANK_M, SETTING} !== exp_flags()) begin
      errors++; $display("FAIL held_btn_single: got %b want %b", {BLANK_H, BLANK_M, SETTING}, exp_flags());
    end
    BTN_MODE = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          repeat ($urandom_range(0, 2)) @(negedge CLK);
          pulse_en();
        end
        2: press(1, 0, 1'($urandom_range(0, 1)));
        3, 4: press(0, 1, 1'($urandom_range(0, 1)));
        default: press(1, 1, 1'($urandom_range(0, 1)));
      endcase
      checks++;
      if ({HOUR, MIN, SEC, BLANK_H, BLANK_M, SETTING} !== {exp_time(), exp_flags()}) begin
        errors++; $display("FAIL random_%0d: got %h/%b want %h/%b", i, {HOUR, MIN, SEC}, {BLANK_H, BLANK_M, SETTING}, exp_time(), exp_flags());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_set_hour();
    test_set_min();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
